// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word_t, the fetch FSM state encoding and the
// small PC arithmetic helpers used by the fetch unit.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Sequential successor; wraps naturally at the top of the address space.
  function automatic word_t pc_plus4(input word_t p);
    return p + word_t'(4);
  endfunction

  function automatic word_t word_align(input word_t a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: instruction memory handshake, control-unit feedback and
// fetch status. Modport fu is the fetch unit side, tb the environment side.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imem_rdata;
  logic  iREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect_en;
  word_t redirect_addr;
  logic  halt_in;
  word_t imemload;
  logic  ivalid;
  word_t pc;
  word_t npc;
  logic  halted;
  logic  misalign;

  modport fu (
    input  ihit, imem_rdata, stall, redirect_en, redirect_addr, halt_in,
    output iREN, imemaddr, imemload, ivalid, pc, npc, halted, misalign
  );

  modport tb (
    output ihit, imem_rdata, stall, redirect_en, redirect_addr, halt_in,
    input  iREN, imemaddr, imemload, ivalid, pc, npc, halted, misalign
  );

endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch FSM (FETCH -> ISSUE -> FETCH, or HALTED).
// Optional macro FETCH_MISALIGN_HALT_EN: misaligned redirect halts and sets misalign.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic    CLK,
  input  logic    RST,
  fetch_unit_if.fu bus
);

  fetch_state_t state_p0, state_nxt;
  word_t        pc_p0, pc_nxt;
  word_t        iload_p0, iload_nxt;

`ifdef FETCH_MISALIGN_HALT_EN
  logic         misalign_p0;
  logic         mis_set;
`endif

  // State register: async reset drops any outstanding request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p0 <= FETCH;
      pc_p0    <= PC_RESET;
      iload_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      pc_p0    <= pc_nxt;
      iload_p0 <= iload_nxt;
    end
  end

`ifdef FETCH_MISALIGN_HALT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      misalign_p0 <= 1'b0;
    end else if (mis_set) begin
      misalign_p0 <= 1'b1;
    end
  end
`endif

  // Next-state: redirect/halt only matter on the retiring ISSUE cycle.
  always_comb begin
    state_nxt = state_p0;
    pc_nxt    = pc_p0;
    iload_nxt = iload_p0;
`ifdef FETCH_MISALIGN_HALT_EN
    mis_set   = 1'b0;
`endif
    case (state_p0)
      FETCH: begin
        if (bus.ihit) begin
          iload_nxt = bus.imem_rdata;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.stall) begin
          if (bus.halt_in) begin
            state_nxt = HALTED;
          end else if (bus.redirect_en) begin
`ifdef FETCH_MISALIGN_HALT_EN
            if (bus.redirect_addr[1:0] != 2'b00) begin
              mis_set   = 1'b1;
              state_nxt = HALTED;
            end else begin
              pc_nxt    = bus.redirect_addr;
              state_nxt = FETCH;
            end
`else
            pc_nxt    = word_align(bus.redirect_addr);
            state_nxt = FETCH;
`endif
          end else begin
            pc_nxt    = pc_plus4(pc_p0);
            state_nxt = FETCH;
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign bus.iREN     = (state_p0 == FETCH);
  assign bus.ivalid   = (state_p0 == ISSUE);
  assign bus.halted   = (state_p0 == HALTED);
  assign bus.imemaddr = pc_p0;
  assign bus.pc       = pc_p0;
  assign bus.npc      = pc_plus4(pc_p0);
  assign bus.imemload = iload_p0;

`ifdef FETCH_MISALIGN_HALT_EN
  assign bus.misalign = misalign_p0;
`else
  assign bus.misalign = 1'b0;
`endif

endmodule
